// File: rtl/hft_pkg.sv
// Shared trade-link definitions: sync byte, message lengths, serializer states, order codes.
package hft_pkg;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
  localparam int         MSG_BYTES_BASE   = 7;
  localparam int         MSG_BYTES_CKSUM  = 8;

  localparam logic [7:0] BUY  = 8'h01;
  localparam logic [7:0] SELL = 8'h02;
  localparam logic [7:0] HOLD = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // XOR of every payload byte that follows the sync byte.
  function automatic logic [7:0] order_checksum(input logic [7:0]  addr,
                                                input logic [7:0]  buysell,
                                                input logic [31:0] ts);
    return addr ^ buysell ^ ts[31:24] ^ ts[23:16] ^ ts[15:8] ^ ts[7:0];
  endfunction

endpackage

// File: rtl/order_tx_framer_if.sv
// Order hand-off between the TX address mux (master) and the framer (slave).
interface order_tx_framer_if;
  logic [7:0]  tx_addr;
  logic [7:0]  tx_buysell;
  logic [31:0] tx_timestamp;
  logic        tx_dv;
  logic        tx_busy;
  logic        tx_done;
  logic        tx;

  modport master (output tx_addr, tx_buysell, tx_timestamp, tx_dv,
                  input  tx_busy, tx_done, tx);
  modport slave  (input  tx_addr, tx_buysell, tx_timestamp, tx_dv,
                  output tx_busy, tx_done, tx);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first; a start seen in the last stop cycle chains the next byte with no gap.
module uart_tx_byte
  import hft_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int              BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         r_state, w_state_nxt;
  logic [BAUD_W-1:0] r_baud,  w_baud_nxt;
  logic [2:0]        r_bit,   w_bit_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              r_tx,    w_tx_nxt;
  logic              w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no branch can infer a latch.
    w_state_nxt = r_state;
    w_baud_nxt  = '0;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    if (r_state != IDLE && !w_bit_end) w_baud_nxt = r_baud + 1'b1;

    case (r_state)
      IDLE: if (start) begin
        w_state_nxt = START;
        w_shift_nxt = byte_in;
        w_tx_nxt    = 1'b0;
      end
      START: if (w_bit_end) begin
        w_state_nxt = DATA;
        w_tx_nxt    = r_shift[0];
      end
      DATA: if (w_bit_end) begin
        w_bit_nxt   = r_bit + 3'd1;
        w_shift_nxt = r_shift >> 1;
        if (r_bit == 3'd7) begin
          w_state_nxt = STOP;
          w_tx_nxt    = 1'b1;
        end else begin
          w_tx_nxt    = r_shift[1];
        end
      end
      STOP: if (w_bit_end) begin
        if (start) begin
          w_state_nxt = START;
          w_shift_nxt = byte_in;
          w_tx_nxt    = 1'b0;
        end else begin
          w_state_nxt = IDLE;
          w_tx_nxt    = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == STOP) && w_bit_end;
  assign tx   = r_tx;

endmodule

// File: rtl/order_tx_framer.sv
// Order framer: captures one order and streams sync + payload bytes as back-to-back 8N1 frames.
// Define ORDER_TX_CHECKSUM_EN to append an XOR checksum byte after the timestamp.
module order_tx_framer
  import hft_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  order_tx_framer_if.slave   bus
);

`ifdef ORDER_TX_CHECKSUM_EN
  localparam int MSG_BYTES = MSG_BYTES_CKSUM;
`else
  localparam int MSG_BYTES = MSG_BYTES_BASE;
`endif
  localparam logic [2:0] LAST_IDX = 3'(MSG_BYTES - 1);

  logic [7:0][7:0] r_msg;
  logic [2:0]      r_idx;
  logic            r_busy;
  logic            r_done;
  logic [2:0]      w_next_idx;
  logic [7:0]      w_cksum;
  logic [7:0]      w_ser_byte;
  logic            w_accept, w_ser_start, w_ser_busy, w_ser_done, w_ser_tx;

`ifdef ORDER_TX_CHECKSUM_EN
  assign w_cksum = order_checksum(bus.tx_addr, bus.tx_buysell, bus.tx_timestamp);
`else
  assign w_cksum = 8'h00;
`endif

  assign w_accept    = bus.tx_dv && !r_busy && !w_ser_busy;
  assign w_next_idx  = r_idx + 3'd1;
  // Next byte is handed over during the last stop cycle so the start bit follows with no gap.
  assign w_ser_start = w_accept || (w_ser_done && (r_idx != LAST_IDX));
  assign w_ser_byte  = w_accept ? HDR_BYTE : r_msg[w_next_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the holding register is only eight bytes, so it is reset with everything else.
      r_msg  <= '0;
      r_idx  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_msg  <= {w_cksum,
                   bus.tx_timestamp[7:0], bus.tx_timestamp[15:8],
                   bus.tx_timestamp[23:16], bus.tx_timestamp[31:24],
                   bus.tx_buysell, bus.tx_addr, HDR_BYTE};
        r_idx  <= '0;
        r_busy <= 1'b1;
      end else if (w_ser_done) begin
        if (r_idx == LAST_IDX) begin
          r_idx  <= '0;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_idx  <= w_next_idx;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk     (clk),
    .reset   (reset),
    .byte_in (w_ser_byte),
    .start   (w_ser_start),
    .busy    (w_ser_busy),
    .done    (w_ser_done),
    .tx      (w_ser_tx)
  );

  assign bus.tx      = w_ser_tx;
  assign bus.tx_busy = r_busy;
  assign bus.tx_done = r_done;

endmodule

// File: tb/tb_order_tx_framer.sv
// Bench for order_tx_framer: per-cycle line model, UART byte sampler and directed order scenarios.
module tb_order_tx_framer;
  import hft_pkg::*;

  localparam int CPB = 4;
`ifdef ORDER_TX_CHECKSUM_EN
  localparam int NB = 8;
`else
  localparam int NB = 7;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  order_tx_framer_if bus();

  order_tx_framer #(
    .CLKS_PER_BIT (CPB),
    .HDR_BYTE     (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line model: the expected tx level for every cycle of each accepted message.
  logic m_q[$];
  logic m_done = 1'b0;

  function automatic void push_msg(input logic [7:0] a, input logic [7:0] bs, input logic [31:0] ts);
    logic [7:0] bytes[$];
    bytes = {8'hA5, a, bs, ts[31:24], ts[23:16], ts[15:8], ts[7:0]};
`ifdef ORDER_TX_CHECKSUM_EN
    bytes.push_back(a ^ bs ^ ts[31:24] ^ ts[23:16] ^ ts[15:8] ^ ts[7:0]);
`endif
    foreach (bytes[k]) begin
      for (int c = 0; c < CPB; c++) m_q.push_back(1'b0);
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < CPB; c++) m_q.push_back(bytes[k][b]);
      for (int c = 0; c < CPB; c++) m_q.push_back(1'b1);
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    logic prev_busy;
    if (reset) begin
      m_q.delete();
      m_done = 1'b0;
    end else begin
      prev_busy = (m_q.size() > 0);
      if (prev_busy) begin
        void'(m_q.pop_front());
        m_done = (m_q.size() == 0);
      end else begin
        m_done = 1'b0;
      end
      if (bus.tx_dv && !prev_busy) push_msg(bus.tx_addr, bus.tx_buysell, bus.tx_timestamp);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("tx_in_reset",   bus.tx,      1'b1);
      check("busy_in_reset", bus.tx_busy, 1'b0);
      check("done_in_reset", bus.tx_done, 1'b0);
    end else begin
      check("tx",   bus.tx,      (m_q.size() > 0) ? m_q[0] : 1'b1);
      check("busy", bus.tx_busy, (m_q.size() > 0));
      check("done", bus.tx_done, m_done);
    end
  end

  // UART sampler: decodes bytes off the line; a reset during a frame discards that frame.
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int rst_gen = 0;

  always @(posedge reset) rst_gen++;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.tx === 1'b0) begin
        int         g;
        logic [7:0] b;
        g = rst_gen;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = bus.tx;
        end
        repeat (CPB) @(negedge clk);
        if (g == rst_gen && !reset && bus.tx === 1'b1) rx_q.push_back(b);
      end
    end
  end

  task automatic check_bytes(input string name);
    check({name, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_b%0d", name, i), rx_q[i], exp_q[i]);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] bs, input logic [31:0] ts);
    @(posedge clk); #2;
    bus.tx_addr      = a;
    bus.tx_buysell   = bs;
    bus.tx_timestamp = ts;
    bus.tx_dv        = 1'b1;
    @(posedge clk); #2;
    bus.tx_dv        = 1'b0;
  endtask

  // Counts cycles from the caller's position until tx_done, returning at the done cycle's negedge.
  task automatic wait_done(output int done_cycle, output int busy_cnt);
    done_cycle = -1;
    busy_cnt   = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (bus.tx_busy === 1'b1) busy_cnt++;
      if (bus.tx_done === 1'b1) begin
        done_cycle = c;
        return;
      end
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  int dc, bc, low_cnt;

  initial begin
    bus.tx_addr      = '0;
    bus.tx_buysell   = '0;
    bus.tx_timestamp = '0;
    bus.tx_dv        = 1'b0;

    // Reset values, then a quiet idle line.
    #1 reset = 1'b1;
    @(negedge clk);
    check("t1_tx",   bus.tx,      1'b1);
    check("t1_busy", bus.tx_busy, 1'b0);
    check("t1_done", bus.tx_done, 1'b0);
    #22 reset = 1'b0;
    low_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) low_cnt++;
    end
    check("t1_idle_low_cycles", low_cnt, 0);

    // Single order: frame length, done position and decoded bytes.
    rx_q.delete();
    send(8'h03, BUY, 32'h12345678);
    wait_done(dc, bc);
    check("t2_busy_cycles", bc, NB * 10 * CPB);
    check("t2_done_cycle",  dc, NB * 10 * CPB + 1);
    @(negedge clk);
    check("t2_done_width",  bus.tx_done, 1'b0);
    repeat (4) @(negedge clk);
    exp_q = {8'hA5, 8'h03, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef ORDER_TX_CHECKSUM_EN
    exp_q.push_back(8'h0A);
`endif
    check_bytes("t2");

    // A second strobe while busy is dropped.
    rx_q.delete();
    send(8'h03, SELL, 32'hCAFEBABE);
    repeat (100) @(negedge clk);
    send(8'h09, BUY, 32'h11111111);
    wait_done(dc, bc);
    repeat (20) @(negedge clk);
    check("t3_idle_after", bus.tx_busy, 1'b0);
    exp_q = {8'hA5, 8'h03, 8'h02, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
`ifdef ORDER_TX_CHECKSUM_EN
    exp_q.push_back(8'h31);
`endif
    check_bytes("t3");

    // Back-to-back: strobe in the done cycle starts the next message on the following cycle.
    rx_q.delete();
    send(8'h05, SELL, 32'h00000001);
    wait_done(dc, bc);
    check("t4_first_done_cycle", dc, NB * 10 * CPB + 1);
    bus.tx_addr      = 8'h06;
    bus.tx_buysell   = HOLD;
    bus.tx_timestamp = 32'hFFFFFFFF;
    bus.tx_dv        = 1'b1;
    @(posedge clk); #2;
    bus.tx_dv        = 1'b0;
    @(negedge clk);
    check("t4_start_tx",   bus.tx,      1'b0);
    check("t4_start_busy", bus.tx_busy, 1'b1);
    wait_done(dc, bc);
    check("t4_second_done_cycle", dc, NB * 10 * CPB);
    repeat (4) @(negedge clk);
    exp_q = {8'hA5, 8'h05, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01};
`ifdef ORDER_TX_CHECKSUM_EN
    exp_q.push_back(8'h06);
`endif
    exp_q = {exp_q, 8'hA5, 8'h06, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`ifdef ORDER_TX_CHECKSUM_EN
    exp_q.push_back(8'h06);
`endif
    check_bytes("t4");

    // Reset during B3 data bits, then a clean order from B0.
    send(8'h07, BUY, 32'hA1B2C3D4);
    repeat (130) @(negedge clk);
    check("t5_tx_before_reset", bus.tx, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("t5_async_tx",   bus.tx,      1'b1);
    check("t5_async_busy", bus.tx_busy, 1'b0);
    #20 reset = 1'b0;
    repeat (50) @(negedge clk);
    rx_q.delete();
    send(8'h0B, HOLD, 32'h0F1E2D3C);
    wait_done(dc, bc);
    check("t5_done_cycle", dc, NB * 10 * CPB + 1);
    repeat (4) @(negedge clk);
    exp_q = {8'hA5, 8'h0B, 8'h00, 8'h0F, 8'h1E, 8'h2D, 8'h3C};
`ifdef ORDER_TX_CHECKSUM_EN
    exp_q.push_back(8'h0B);
`endif
    check_bytes("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
